irrigation_sensor_frontend: RTL and testbench
=============================================

Name: irrigation_sensor_frontend

Overview:
Conditions the raw field-sensor lines into the clean, stable flags the sprinkler-pump decision logic consumes: earth_humidity, air_humidity, low_temperature and mid_water_level. Each raw line is synchronised and debounced. The three water-level probes are decoded as a thermometer code with fault detection. A start-up state machine holds the flags invalid until every channel has settled. It sits between the sensor pins and the combinational irrigation decision logic.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive cycles a synchronised input must differ from its debounced value before the debounced value updates (minimum 2).
CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the debounce and settle counters.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous, active-low reset.
raw_earth_humidity  input  1  raw soil-humidity sensor, 1 = humid.
raw_air_humidity  input  1  raw air-humidity sensor, 1 = humid.
raw_low_temperature  input  1  raw thermostat, 1 = temperature low.
raw_level_probe  input  3  tank probes; bit0 = low, bit1 = mid, bit2 = high; 1 = submerged.
earth_humidity  output  1  conditioned soil humidity.
air_humidity  output  1  conditioned air humidity.
low_temperature  output  1  conditioned low-temperature flag.
low_water_level  output  1  water at or above the low probe.
mid_water_level  output  1  water at or above the mid probe.
high_water_level  output  1  water at or above the high probe.
level_fault  output  1  debounced probe code is not a legal thermometer code.
flags_valid  output  1  all outputs are settled and trustworthy.
change_pulse  output  1  one-cycle strobe when any conditioned output changes.

Behaviour:
- Reset (asynchronous, rst_n = 0): all outputs, synchroniser flops, debounced values and counters go to 0. FSM enters WARMUP. Deassertion takes effect on the next clk edge.
- Synchroniser: 2-flop chain per raw bit (6 bits total).
- Debounce, per bit:
  - cnt counts cycles where synced != deb and clears to 0 whenever synced == deb.
  - When synced != deb and cnt == DEBOUNCE_CYCLES-1: deb <= synced and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches deb.
- Decode/output stage is registered:
  - Humidity and temperature outputs copy deb.
  - Probe code deb[2:0] legal values are 000, 001, 011, 111. These drive low/mid/high = code bits, level_fault = 0.
  - Illegal codes (010, 100, 101, 110) set level_fault = 1, and low/mid/high hold their last legal values.
- Latency: if a raw change is first sampled on edge 1 and held stable, the output changes after edge 3 + DEBOUNCE_CYCLES.
- FSM:
  - WARMUP: settle_cnt increments each cycle where every channel has cnt == 0 and synced == deb. Otherwise settle_cnt clears. When settle_cnt == DEBOUNCE_CYCLES, go to RUN.
  - RUN: flags_valid = 1 (registered, asserted the cycle after the transition). RUN is left only by reset.
- change_pulse: in RUN only. High for exactly one cycle after any registered output among the six flags or level_fault changes. Simultaneous changes produce a single pulse. It never asserts in WARMUP.
- Reset mid-debounce discards partial counts. After reset the block behaves exactly as from power-up.

Decomposition:
- Package irrigation_pkg:
  - FSM state typedef (WARMUP, RUN).
  - Probe index constants PROBE_LOW = 0, PROBE_MID = 1, PROBE_HIGH = 2.
  - Legal level-code constants LEVEL_EMPTY = 000, LEVEL_LOW = 001, LEVEL_MID = 011, LEVEL_FULL = 111.
- Sub-module debounce_channel, instantiated 6 times. It contains the 2-flop sync, the counter and deb. It outputs deb plus an idle flag (cnt == 0 and synced == deb).

Test Plan (DEBOUNCE_CYCLES = 4):
- All raw = 0 after reset release -> flags_valid rises after 4 settle cycles + transition/register latency. All flags = 0, change_pulse never asserted.
- In RUN, raw_earth_humidity 0 -> 1 held, first sampled on edge 1 -> earth_humidity = 1 after edge 7. change_pulse high for exactly that one following cycle.
- In RUN, raw_air_humidity pulsed high for 3 cycles -> air_humidity stays 0, no change_pulse.
- raw_level_probe 000 -> 001 -> 011 -> 111, each held 10 cycles -> low/mid/high follow the thermometer code, one change_pulse per step. Then 101 held -> level_fault = 1 with low = mid = high = 1 held, plus one change_pulse. Then 011 -> level_fault = 0, high = 0.
- rst_n asserted mid-debounce (count = 2) with raw_low_temperature = 1 -> outputs 0 immediately. After release the FSM returns to WARMUP, and low_temperature rises only after a full debounce window.
- raw_earth_humidity and raw_level_probe bit0 change on the same edge -> both outputs update together with a single change_pulse.

Source files
------------

// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared types and constants for the irrigation sensor front end.
// Revision 1.0
`default_nettype none

package irrigation_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } fsm_state_t;

  localparam int PROBE_LOW  = 0;
  localparam int PROBE_MID  = 1;
  localparam int PROBE_HIGH = 2;

  localparam logic [2:0] LEVEL_EMPTY = 3'b000;
  localparam logic [2:0] LEVEL_LOW   = 3'b001;
  localparam logic [2:0] LEVEL_MID   = 3'b011;
  localparam logic [2:0] LEVEL_FULL  = 3'b111;

  // Channel order inside the debounced bus; probes occupy the top three bits.
  localparam int NUM_CHANNELS = 6;
  localparam int CH_EARTH     = 0;
  localparam int CH_AIR       = 1;
  localparam int CH_TEMP      = 2;
  localparam int CH_PROBE     = 3;

  function automatic logic level_code_legal(input logic [2:0] code);
    logic legal;
    case (code)
      LEVEL_EMPTY, LEVEL_LOW, LEVEL_MID, LEVEL_FULL: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchroniser followed by a consecutive-cycle debouncer.
// Revision 1.0
`default_nettype none

module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb,
  output logic idle
);

  logic             sync1;
  logic             synced;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      deb    <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= raw;
      synced <= sync1;
      if (synced == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb <= synced;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign idle = (cnt == '0) && (synced == deb);

endmodule

`default_nettype wire

// File: rtl/irrigation_sensor_frontend.sv
// irrigation_sensor_frontend: debounces field sensors, decodes tank probes, gates flags until settled.
// Revision 1.0
`default_nettype none

module irrigation_sensor_frontend
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_earth_humidity,
  input  logic       raw_air_humidity,
  input  logic       raw_low_temperature,
  input  logic [2:0] raw_level_probe,
  output logic       earth_humidity,
  output logic       air_humidity,
  output logic       low_temperature,
  output logic       low_water_level,
  output logic       mid_water_level,
  output logic       high_water_level,
  output logic       level_fault,
  output logic       flags_valid,
  output logic       change_pulse
);

  logic [NUM_CHANNELS-1:0] raw_bus;
  logic [NUM_CHANNELS-1:0] deb_bus;
  logic [NUM_CHANNELS-1:0] idle_bus;

  assign raw_bus = {raw_level_probe, raw_low_temperature, raw_air_humidity, raw_earth_humidity};

  generate
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw_bus[i]),
        .deb  (deb_bus[i]),
        .idle (idle_bus[i])
      );
    end
  endgenerate

  logic [2:0] level_code;
  logic       next_low;
  logic       next_mid;
  logic       next_high;
  logic       next_fault;
  logic [6:0] cur_flags;
  logic [6:0] next_flags;

  assign level_code = deb_bus[CH_PROBE +: 3];

  // Illegal probe codes keep the last trusted level and only raise the fault flag.
  always_comb begin
    next_low   = low_water_level;
    next_mid   = mid_water_level;
    next_high  = high_water_level;
    next_fault = 1'b1;
    if (level_code_legal(level_code)) begin
      next_low   = level_code[PROBE_LOW];
      next_mid   = level_code[PROBE_MID];
      next_high  = level_code[PROBE_HIGH];
      next_fault = 1'b0;
    end
  end

  assign cur_flags  = {earth_humidity, air_humidity, low_temperature,
                       low_water_level, mid_water_level, high_water_level, level_fault};
  assign next_flags = {deb_bus[CH_EARTH], deb_bus[CH_AIR], deb_bus[CH_TEMP],
                       next_low, next_mid, next_high, next_fault};

  fsm_state_t       state;
  logic [CNT_W-1:0] settle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= WARMUP;
      settle_cnt       <= '0;
      flags_valid      <= 1'b0;
      change_pulse     <= 1'b0;
      earth_humidity   <= 1'b0;
      air_humidity     <= 1'b0;
      low_temperature  <= 1'b0;
      low_water_level  <= 1'b0;
      mid_water_level  <= 1'b0;
      high_water_level <= 1'b0;
      level_fault      <= 1'b0;
    end else begin
      earth_humidity   <= next_flags[6];
      air_humidity     <= next_flags[5];
      low_temperature  <= next_flags[4];
      low_water_level  <= next_flags[3];
      mid_water_level  <= next_flags[2];
      high_water_level <= next_flags[1];
      level_fault      <= next_flags[0];
      change_pulse     <= (state == RUN) && (next_flags != cur_flags);
      flags_valid      <= (state == RUN);
      case (state)
        WARMUP: begin
          if (settle_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
            state <= RUN;
          end else if (&idle_bus) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end else begin
            settle_cnt <= '0;
          end
        end
        RUN:     state <= RUN;
        default: state <= WARMUP;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irrigation_sensor_frontend.sv
// tb_irrigation_sensor_frontend: table vectors, hand corner sequences and random traffic vs a reference model.
// Revision 1.0
`default_nettype none

module tb_irrigation_sensor_frontend;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       raw_earth_humidity, raw_air_humidity, raw_low_temperature;
  logic [2:0] raw_level_probe;
  logic       earth_humidity, air_humidity, low_temperature;
  logic       low_water_level, mid_water_level, high_water_level;
  logic       level_fault, flags_valid, change_pulse;

  irrigation_sensor_frontend #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .raw_earth_humidity (raw_earth_humidity),
    .raw_air_humidity   (raw_air_humidity),
    .raw_low_temperature(raw_low_temperature),
    .raw_level_probe    (raw_level_probe),
    .earth_humidity     (earth_humidity),
    .air_humidity       (air_humidity),
    .low_temperature    (low_temperature),
    .low_water_level    (low_water_level),
    .mid_water_level    (mid_water_level),
    .high_water_level   (high_water_level),
    .level_fault        (level_fault),
    .flags_valid        (flags_valid),
    .change_pulse       (change_pulse)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model: a channel's filtered value flips once the last DC synchronised
  // observations all disagree with it; a channel is quiet when its current and
  // previous observation both agree with the filtered value.
  logic [5:0] m_s1, m_s2, m_deb, m_last;
  logic [5:0] m_hist[$];
  logic [6:0] m_out;
  logic       m_valid, m_pulse, m_run;
  int         m_settle;

  typedef struct {
    logic       e, a, t;
    logic [2:0] p;
    logic [6:0] exp;
    int         exp_pulses;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [8:0] dut_vec();
    return {earth_humidity, air_humidity, low_temperature, low_water_level,
            mid_water_level, high_water_level, level_fault, flags_valid, change_pulse};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_last = '0;
    m_hist.delete();
    m_out = '0; m_valid = 1'b0; m_pulse = 1'b0; m_run = 1'b0; m_settle = 0;
  endtask

  task automatic model_step();
    logic [5:0] seen;
    logic [6:0] nxt;
    logic [2:0] code;
    logic       quiet;
    int         n;
    seen  = m_s2;
    quiet = (((m_s2 ^ m_deb) | (m_last ^ m_deb)) == 6'b0);
    code  = m_deb[5:3];
    nxt   = m_out;
    nxt[6] = m_deb[0];
    nxt[5] = m_deb[1];
    nxt[4] = m_deb[2];
    if (code == 3'b000 || code == 3'b001 || code == 3'b011 || code == 3'b111) begin
      nxt[3] = code[0]; nxt[2] = code[1]; nxt[1] = code[2]; nxt[0] = 1'b0;
    end else begin
      nxt[0] = 1'b1;
    end
    m_pulse = m_run && (nxt != m_out);
    m_valid = m_run;
    m_out   = nxt;
    if (!m_run) begin
      if (m_settle == DC) m_run = 1'b1;
      else if (quiet)     m_settle++;
      else                m_settle = 0;
    end
    m_hist.push_back(seen);
    if (m_hist.size() > DC) void'(m_hist.pop_front());
    if (m_hist.size() == DC) begin
      for (int ch = 0; ch < 6; ch++) begin
        n = 0;
        foreach (m_hist[i]) if (m_hist[i][ch] != m_deb[ch]) n++;
        if (n == DC) m_deb[ch] = ~m_deb[ch];
      end
    end
    m_last = seen;
    m_s2   = m_s1;
    m_s1   = {raw_level_probe, raw_low_temperature, raw_air_humidity, raw_earth_humidity};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    chk("model", {23'd0, dut_vec()}, {23'd0, m_out, m_valid, m_pulse});
    if (change_pulse) pulses++;
  endtask

  task automatic set_raw(input logic e, input logic a, input logic t, input logic [2:0] p);
    raw_earth_humidity  = e;
    raw_air_humidity    = a;
    raw_low_temperature = t;
    raw_level_probe     = p;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 7'b1000000, 1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'b001, 7'b1001000, 1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'b011, 7'b1001100, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'b111, 7'b1001110, 1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'b101, 7'b1001111, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'b011, 7'b1001100, 1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 3'b000, 7'b1110000, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 3'b110, 7'b1110001, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 3'b001, 7'b0001000, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'b001, 7'b0001000, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 3'b000, 7'b0000000, 1};

    rst_n = 1'b0;
    set_raw(1'b0, 1'b0, 1'b0, 3'b000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {23'd0, dut_vec()}, 32'd0);
    rst_n = 1'b1;

    // Start-up: quiet inputs settle for DC cycles, then RUN, then valid.
    pulses = 0;
    repeat (5) tick();
    chk("valid_early", {31'd0, flags_valid}, 32'd0);
    tick();
    chk("valid_rise", {31'd0, flags_valid}, 32'd1);
    chk("warmup_no_pulse", pulses, 0);

    // Latency: sampled on edge 1, visible after edge 3+DC.
    set_raw(1'b1, 1'b0, 1'b0, 3'b000);
    pulses = 0;
    repeat (6) tick();
    chk("earth_before", {31'd0, earth_humidity}, 32'd0);
    tick();
    chk("earth_after", {31'd0, earth_humidity}, 32'd1);
    chk("earth_pulse", {31'd0, change_pulse}, 32'd1);
    tick();
    chk("earth_pulse_end", {31'd0, change_pulse}, 32'd0);

    // Short glitch on air humidity is filtered.
    set_raw(1'b1, 1'b1, 1'b0, 3'b000);
    repeat (3) tick();
    set_raw(1'b1, 1'b0, 1'b0, 3'b000);
    pulses = 0;
    repeat (10) tick();
    chk("glitch_air", {31'd0, air_humidity}, 32'd0);
    chk("glitch_pulse", pulses, 0);
    set_raw(1'b0, 1'b0, 1'b0, 3'b000);
    repeat (10) tick();

    for (int i = 0; i < 11; i++) begin
      set_raw(tbl[i].e, tbl[i].a, tbl[i].t, tbl[i].p);
      pulses = 0;
      repeat (10) tick();
      chk($sformatf("vec%0d_flags", i),
          {25'd0, earth_humidity, air_humidity, low_temperature, low_water_level,
           mid_water_level, high_water_level, level_fault}, {25'd0, tbl[i].exp});
      chk($sformatf("vec%0d_pulses", i), pulses, tbl[i].exp_pulses);
    end

    // Two channels switching together give one combined pulse.
    set_raw(1'b1, 1'b0, 1'b0, 3'b001);
    pulses = 0;
    repeat (6) tick();
    chk("simul_before", {30'd0, earth_humidity, low_water_level}, 32'd0);
    tick();
    chk("simul_after", {30'd0, earth_humidity, low_water_level}, 32'd3);
    chk("simul_pulse", {31'd0, change_pulse}, 32'd1);
    repeat (5) tick();
    chk("simul_pulse_count", pulses, 1);
    set_raw(1'b0, 1'b0, 1'b0, 3'b000);
    repeat (10) tick();

    for (int r = 0; r < 60; r++) begin
      set_raw(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      repeat ($urandom_range(1, 9)) tick();
    end
    set_raw(1'b0, 1'b0, 1'b0, 3'b000);
    repeat (10) tick();

    // Reset in the middle of a debounce window.
    set_raw(1'b0, 1'b0, 1'b1, 3'b000);
    repeat (4) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_async", {23'd0, dut_vec()}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("temp_before", {31'd0, low_temperature}, 32'd0);
    tick();
    chk("temp_after", {31'd0, low_temperature}, 32'd1);
    chk("temp_warmup_valid", {30'd0, flags_valid, change_pulse}, 32'd0);
    repeat (20) tick();
    chk("rewarm_valid", {31'd0, flags_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
